cdb_broadcaster: RTL and testbench
==================================

// Module: cdb_broadcaster
// PURPOSE
//  Producer-side end of the common data bus. Collects results from up to NUM_SRC
//  functional units/reservation stations over a valid/ready handshake and buffers
//  them in per-source FIFOs. Broadcasts up to 4 results per cycle on the serialized
//  4-slot CDB that every reservation station and the regfile snoop.
//  Sits between the FU result ports and the CDB_data_serialized/CDB_tag_serialized nets.
// PARAMETERS
//  NUM_SRC     8   number of producer ports (>=4); rr pointer width = $clog2(NUM_SRC)
//  FIFO_DEPTH  4   entries per source FIFO (power of 2, >=2)
// PORTS
//  clk                  in   1            single clock, all state on posedge
//  reset                in   1            synchronous, active-low reset
//  en                   in   1            global enable, shared with all RS units
//  src_valid            in   NUM_SRC      per-source result valid
//  src_data             in   NUM_SRC*32   result data, source k at [32k+31:32k]
//  src_tag              in   NUM_SRC*8    result tag {valid,mem,add,mul,div,3'dID}, source k at [8k+7:8k]
//  src_ready            out  NUM_SRC      per-source FIFO can accept this cycle
//  CDB_data_serialized  out  128          {slot0,slot1,slot2,slot3} data, slot0 = [127:96]
//  CDB_tag_serialized   out  32           {slot0,slot1,slot2,slot3} tags, slot0 = [31:24]
//  cdb_slots_used       out  3            number of valid slots broadcast this cycle (0..4)
// BEHAVIOUR
//  Reset (reset==0 at posedge): every FIFO emptied, rr_ptr=0, CDB_data_serialized=0,
//   CDB_tag_serialized=0, cdb_slots_used=0; contents in flight are discarded.
//   src_ready=0 while reset==0 (combinational).
//  src_ready[k] = reset & en & (count[k] != FIFO_DEPTH). Depends on count only; a pop
//   in the same cycle does not free a slot for a push.
//  Push: src_valid[k] & src_ready[k] at posedge writes {src_tag,src_data} to FIFO k.
//   The tag is stored and broadcast unmodified. src_valid while !src_ready: no push;
//   the producer holds its data.
//  Arbitration (combinational on FIFO state): scan sources rr_ptr, rr_ptr+1, ...
//   mod NUM_SRC; grant the first up to 4 non-empty FIFOs, in scan order, to slots
//   0..3. Granted FIFOs pop at the same posedge at which their heads are registered.
//  Output: CDB registers load at posedge when en & reset. Slots with no grant get
//   tag 8'h00 and data 32'h0. cdb_slots_used = number of grants.
//  rr_ptr: if any grant, becomes (index of last granted source + 1) mod NUM_SRC;
//   otherwise unchanged.
//  Latency: a result pushed at edge E is on the CDB, at the earliest, for the cycle
//   after edge E+1. That is 1 cycle of bus-visible delay, with no combinational
//   input-to-CDB path.
//  Each output value is valid for exactly one cycle. Every accepted result is
//   broadcast exactly once. Per-source order is FIFO order.
//  Simultaneous push and pop on FIFO k: both occur; count unchanged; wrap-around of
//   rd/wr pointers modulo FIFO_DEPTH.
//  Full FIFO: src_ready low and no push; data is never overwritten or dropped.
//  Empty FIFOs: never granted. If all are empty, next-cycle CDB is all-zero.
//  en==0 at posedge: no push, no pop, FIFO and rr_ptr hold; the CDB registers load 0.
//   This prevents a rebroadcast of the previous tags.
//  A reset mid-burst takes priority over en and over pushes/pops in the same cycle.
// TESTING
//  1 reset=0 for 2 cycles with src_valid=8'hFF -> CDB outputs 0, src_ready=0,
//    slots_used=0; 1 cycle after release with en=1, src_ready=8'hFF.
//  2 src3 pushes data 32'h64, tag 8'h8B at edge E -> after E+1: CDB_tag[31:24]=8'h8B,
//    CDB_data[127:96]=32'h64, other slots 0, slots_used=1; next cycle all 0.
//  3 all 8 push once at E, rr_ptr=0 -> after E+1: slots = src0..src3 tags; after E+2:
//    src4..src7 tags; rr_ptr=0; after E+3: empty.
//  4 all 8 push every cycle with data = {src,seq} -> each src_ready drops once
//    count==4; every {src,seq} appears exactly once, in seq order per source.
//  5 stream as in 4, drop en for 1 cycle -> CDB all-zero next cycle, FIFO counts and
//    rr_ptr unchanged; after en=1 the scan resumes at the held rr_ptr, with no
//    duplicates.
//  6 FIFOs full, then reset=0 for 1 cycle -> CDB 0 afterwards, counts 0, no stale
//    tag is broadcast after release.

Source files
------------

// File: rtl/cdb_broadcaster_if.sv
// rtl/cdb_broadcaster_if.sv - producer handshake and serialized CDB bundle
interface cdb_broadcaster_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC*32-1:0] src_data;
  logic [NUM_SRC*8-1:0]  src_tag;
  logic [NUM_SRC-1:0]    src_ready;
  logic [127:0]          CDB_data_serialized;
  logic [31:0]           CDB_tag_serialized;
  logic [2:0]            cdb_slots_used;

  modport master (
    output src_valid, src_data, src_tag,
    input  src_ready, CDB_data_serialized, CDB_tag_serialized, cdb_slots_used
  );

  modport slave (
    input  src_valid, src_data, src_tag,
    output src_ready, CDB_data_serialized, CDB_tag_serialized, cdb_slots_used
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - per-source result FIFOs with round-robin 4-slot CDB broadcast
module cdb_broadcaster #(
  parameter int NUM_SRC    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  cdb_broadcaster_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int FW    = $clog2(FIFO_DEPTH);
  localparam int CW    = FW + 1;

  logic [39:0]        mem    [NUM_SRC][FIFO_DEPTH];
  logic [FW-1:0]      rd_ptr [NUM_SRC];
  logic [FW-1:0]      wr_ptr [NUM_SRC];
  logic [CW-1:0]      count  [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   slot_src [4];
  logic [3:0]         slot_vld;
  logic [2:0]         n_grant;
  logic [PTR_W-1:0]   last_src;
  logic [PTR_W-1:0]   idx;

  logic [127:0]       cdb_data_n, cdb_data_q;
  logic [31:0]        cdb_tag_n, cdb_tag_q;
  logic [2:0]         slots_q;
  logic [39:0]        head;

  function automatic logic [PTR_W-1:0] wrap_add(logic [PTR_W-1:0] a, int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return PTR_W'(s);
  endfunction

  // Ready looks at the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      ready[k] = reset & en & (count[k] != CW'(FIFO_DEPTH));
    end
    push = bus.src_valid & ready;
  end

  always_comb begin
    grant    = '0;
    slot_vld = '0;
    n_grant  = 3'd0;
    last_src = rr_ptr;
    idx      = '0;
    for (int s = 0; s < 4; s++) slot_src[s] = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = wrap_add(rr_ptr, i);
      if (count[idx] != '0 && n_grant < 3'd4) begin
        grant[idx]                 = 1'b1;
        slot_src[n_grant[1:0]]     = idx;
        slot_vld[n_grant[1:0]]     = 1'b1;
        n_grant                    = n_grant + 3'd1;
        last_src                   = idx;
      end
    end
  end

  always_comb begin
    cdb_data_n = '0;
    cdb_tag_n  = '0;
    head       = '0;
    for (int s = 0; s < 4; s++) begin
      head = mem[slot_src[s]][rd_ptr[slot_src[s]]];
      if (slot_vld[s]) begin
        cdb_data_n[127-32*s -: 32] = head[31:0];
        cdb_tag_n[31-8*s -: 8]     = head[39:32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      rr_ptr     <= '0;
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
      slots_q    <= '0;
    end else if (en) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= {bus.src_tag[8*k +: 8], bus.src_data[32*k +: 32]};
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (grant[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + CW'(push[k]) - CW'(grant[k]);
      end
      if (n_grant != 3'd0) rr_ptr <= wrap_add(last_src, 1);
      cdb_data_q <= cdb_data_n;
      cdb_tag_q  <= cdb_tag_n;
      slots_q    <= n_grant;
    end else begin
      // Idle cycle drives an empty bus so snoopers never see a repeated tag.
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
      slots_q    <= '0;
    end
  end

  assign bus.src_ready           = ready;
  assign bus.CDB_data_serialized = cdb_data_q;
  assign bus.CDB_tag_serialized  = cdb_tag_q;
  assign bus.cdb_slots_used      = slots_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - randomized bench with queue-based reference model for cdb_broadcaster
module tb_cdb_broadcaster;
  localparam int N = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NUM_SRC(N)) bus ();
  cdb_broadcaster #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [39:0]  mq [N][$];
  int           m_rr = 0;
  logic [127:0] exp_data = '0;
  logic [31:0]  exp_tag = '0;
  logic [2:0]   exp_used = '0;
  bit           started = 0;
  bit           order_chk = 0;
  int           next_out [N];
  int           seq_in [N];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: rotate through sources from the pointer, take up to four non-empty queues.
  always @(posedge clk) begin
    bit          rdy [N];
    int          n;
    int          last;
    int          k;
    logic [39:0] e;
    started = 1;
    if (!reset) begin
      for (int j = 0; j < N; j++) mq[j].delete();
      m_rr = 0; exp_data = '0; exp_tag = '0; exp_used = '0;
    end else if (!en) begin
      exp_data = '0; exp_tag = '0; exp_used = '0;
    end else begin
      for (int j = 0; j < N; j++) rdy[j] = mq[j].size() < D;
      exp_data = '0; exp_tag = '0; n = 0; last = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (n < 4 && mq[k].size() > 0) begin
          e = mq[k].pop_front();
          exp_tag[31-8*n -: 8]    = e[39:32];
          exp_data[127-32*n -: 32] = e[31:0];
          n++;
          last = k;
        end
      end
      for (int j = 0; j < N; j++)
        if (bus.src_valid[j] && rdy[j])
          mq[j].push_back({bus.src_tag[8*j +: 8], bus.src_data[32*j +: 32]});
      exp_used = 3'(n);
      if (n > 0) m_rr = (last + 1) % N;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    int src;
    int sq;
    logic [31:0] d;
    if (started) begin
      for (int j = 0; j < N; j++) er[j] = reset && en && (mq[j].size() < D);
      check("src_ready", 128'(bus.src_ready), 128'(er));
      check("cdb_tag", 128'(bus.CDB_tag_serialized), 128'(exp_tag));
      check("cdb_data", bus.CDB_data_serialized, exp_data);
      check("slots_used", 128'(bus.cdb_slots_used), 128'(exp_used));
      if (order_chk) begin
        for (int s = 0; s < 4; s++) begin
          if (s < int'(bus.cdb_slots_used)) begin
            d   = bus.CDB_data_serialized[127-32*s -: 32];
            src = int'(d[31:24]);
            sq  = int'(d[23:0]);
            if (src < N) begin
              check("seq_order", 128'(sq), 128'(next_out[src]));
              next_out[src]++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] acc;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_tag   = '0;
    en = 1'b1;

    reset = 1'b0;
    bus.src_valid = '1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ready", 128'(bus.src_ready), 128'(0));
      check("rst_tag", 128'(bus.CDB_tag_serialized), 128'(0));
      check("rst_used", 128'(bus.cdb_slots_used), 128'(0));
    end
    bus.src_valid = '0;
    reset = 1'b1;
    step();
    check("release_ready", 128'(bus.src_ready), 128'(8'hFF));

    bus.src_valid = 8'h08;
    bus.src_data[96 +: 32] = 32'h64;
    bus.src_tag[24 +: 8]   = 8'h8B;
    step();
    bus.src_valid = '0;
    step();
    check("single_tag", 128'(bus.CDB_tag_serialized), 128'(32'h8B00_0000));
    check("single_data", bus.CDB_data_serialized, {32'h64, 96'h0});
    check("single_used", 128'(bus.cdb_slots_used), 128'(1));
    step();
    check("single_after", 128'(bus.CDB_tag_serialized), 128'(0));

    reset_pulse();
    for (int k = 0; k < N; k++) begin
      bus.src_data[32*k +: 32] = 32'h100 + 32'(k);
      bus.src_tag[8*k +: 8]    = 8'h80 + 8'(k);
    end
    bus.src_valid = '1;
    step();
    bus.src_valid = '0;
    step();
    check("burst_tag0", 128'(bus.CDB_tag_serialized), 128'(32'h8081_8283));
    check("burst_data0", 128'(bus.CDB_data_serialized[127:96]), 128'(32'h100));
    check("burst_used0", 128'(bus.cdb_slots_used), 128'(4));
    step();
    check("burst_tag1", 128'(bus.CDB_tag_serialized), 128'(32'h8485_8687));
    step();
    check("burst_empty", 128'(bus.CDB_tag_serialized), 128'(0));
    check("burst_empty_used", 128'(bus.cdb_slots_used), 128'(0));

    reset_pulse();
    for (int k = 0; k < N; k++) begin
      seq_in[k] = 0;
      next_out[k] = 0;
    end
    order_chk = 1;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.src_valid[k])
          bus.src_valid[k] = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.src_data[32*k +: 32] = {8'(k), 24'(seq_in[k])};
        bus.src_tag[8*k +: 8]    = {1'b1, 4'(seq_in[k]), 3'(k)};
      end
      en = !(c == 60 || c == 130);
      #1;
      acc = bus.src_valid & bus.src_ready;
      step();
      if (c == 60 || c == 130) begin
        check("en_low_tag", 128'(bus.CDB_tag_serialized), 128'(0));
        check("en_low_used", 128'(bus.cdb_slots_used), 128'(0));
      end
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          seq_in[k]++;
          bus.src_valid[k] = 1'b0;
        end
      end
    end
    bus.src_valid = '0;
    en = 1'b1;
    for (int c = 0; c < 12; c++) step();
    for (int k = 0; k < N; k++) check("all_broadcast", 128'(next_out[k]), 128'(seq_in[k]));
    order_chk = 0;

    bus.src_valid = '1;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b0;
    step();
    check("midrst_tag", 128'(bus.CDB_tag_serialized), 128'(0));
    check("midrst_ready", 128'(bus.src_ready), 128'(0));
    reset = 1'b1;
    bus.src_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_tag", 128'(bus.CDB_tag_serialized), 128'(0));
      check("post_rst_used", 128'(bus.cdb_slots_used), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
